// File: rtl/mem_bank_arbiter.sv
// rtl/mem_bank_arbiter.sv - per-bank round-robin arbiter between NREQ requesters and unifiedmem
// Define MEMARB_ERR_EN to add the sticky out-of-range error outputs err_flag/err_req.
module mem_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int NBANK = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*3-1:0]      req_bank,
  input  logic [NREQ*WIDTH-1:0]  req_addr,
  input  logic [NREQ*8-1:0]      req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*8-1:0]      rsp_rdata,
  output logic [NBANK-1:0]       mem_we,
  output logic [WIDTH*NBANK-1:0] mem_a,
  output logic [WIDTH*NBANK-1:0] mem_wd,
  input  logic [8*NBANK-1:0]     mem_rd
`ifdef MEMARB_ERR_EN
  ,
  output logic                   err_flag,
  output logic [$clog2(NREQ)-1:0] err_req
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0]   ptr_q [NBANK];
  logic [PTRW-1:0]   ptr_d [NBANK];
  logic [NBANK-1:0]  bank_gnt;
  logic [PTRW-1:0]   bank_win [NBANK];
  logic [NREQ-1:0]   oor;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NREQ*8-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin : decode_range
    oor = '0;
    for (int i = 0; i < NREQ; i++) begin
      oor[i] = (int'(req_bank[3*i +: 3]) >= NBANK);
    end
  end

  // First in-range candidate at or after ptr[b]; reset suppresses every grant.
  always_comb begin : arbitrate
    int idx;
    idx      = 0;
    bank_gnt = '0;
    for (int b = 0; b < NBANK; b++) begin
      bank_win[b] = '0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q[b]) + k) % NREQ;
        if (!bank_gnt[b] && req_valid[idx] && !oor[idx] &&
            int'(req_bank[3*idx +: 3]) == b) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = PTRW'(idx);
        end
      end
      if (reset) begin
        bank_gnt[b] = 1'b0;
      end
    end
  end

  always_comb begin : drive_mem
    req_ready = '0;
    mem_we    = '0;
    mem_a     = '0;
    mem_wd    = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_gnt[b]) begin
        req_ready[bank_win[b]]     = 1'b1;
        mem_we[b]                  = req_we[bank_win[b]];
        mem_a[WIDTH*b +: WIDTH]    = req_addr[WIDTH*bank_win[b] +: WIDTH];
        mem_wd[WIDTH*b +: WIDTH]   = {{(WIDTH-8){1'b0}}, req_wdata[8*bank_win[b] +: 8]};
      end
    end
    // Nonexistent banks have no contention, so these are accepted at once.
    for (int i = 0; i < NREQ; i++) begin
      if (!reset && req_valid[i] && oor[i]) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin : respond
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && !req_we[i]) begin
        rsp_valid_d[i]       = 1'b1;
        rsp_rdata_d[8*i +: 8] = 8'h00;
        for (int b = 0; b < NBANK; b++) begin
          if (!oor[i] && int'(req_bank[3*i +: 3]) == b) begin
            rsp_rdata_d[8*i +: 8] = mem_rd[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin : next_ptr
    for (int b = 0; b < NBANK; b++) begin
      ptr_d[b] = ptr_q[b];
      if (bank_gnt[b]) begin
        ptr_d[b] = (int'(bank_win[b]) == NREQ-1) ? '0 : bank_win[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBANK; b++) begin
        ptr_q[b] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        ptr_q[b] <= ptr_d[b];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef MEMARB_ERR_EN
  logic            err_flag_q, err_flag_d;
  logic [PTRW-1:0] err_req_q, err_req_d;

  // Descending scan so the lowest offending index is the one captured.
  always_comb begin : err_next
    err_flag_d = err_flag_q;
    err_req_d  = err_req_q;
    if (!err_flag_q) begin
      for (int i = NREQ-1; i >= 0; i--) begin
        if (req_ready[i] && oor[i]) begin
          err_flag_d = 1'b1;
          err_req_d  = PTRW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag_q <= 1'b0;
      err_req_q  <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_req_q  <= err_req_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_req  = err_req_q;
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb/tb_mem_bank_arbiter.sv - directed self-checking bench for mem_bank_arbiter
`timescale 1ns/1ps
module tb_mem_bank_arbiter;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int NBANK = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NREQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*3-1:0]      req_bank;
  logic [NREQ*WIDTH-1:0]  req_addr;
  logic [NREQ*8-1:0]      req_wdata, rsp_rdata;
  logic [NBANK-1:0]       mem_we;
  logic [WIDTH*NBANK-1:0] mem_a, mem_wd;
  logic [8*NBANK-1:0]     mem_rd;
`ifdef MEMARB_ERR_EN
  logic                   err_flag;
  logic [1:0]             err_req;
`endif

  int total = 0;
  int bad   = 0;

  mem_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NBANK(NBANK)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef MEMARB_ERR_EN
    , .err_flag(err_flag), .err_req(err_req)
`endif
  );

  // Memory model: unwritten locations read a fixed pattern.
  logic [7:0] mem [NBANK][256];
  bit         written [NBANK][256];

  function automatic logic [7:0] exp_byte(input int b, input int a);
    return 8'(8'h11 + b*32 + a);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (mem_we[b]) begin
        mem[b][mem_a[WIDTH*b +: 8]]     <= mem_wd[WIDTH*b +: 8];
        written[b][mem_a[WIDTH*b +: 8]] <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_rd = '0;
    for (int b = 0; b < NBANK; b++) begin
      mem_rd[8*b +: 8] = written[b][mem_a[WIDTH*b +: 8]] ? mem[b][mem_a[WIDTH*b +: 8]]
                                                          : exp_byte(b, int'(mem_a[WIDTH*b +: 8]));
    end
  end

  task automatic idle_all();
    req_valid = '0; req_we = '0; req_bank = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input int bank, input int addr, input int wd);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_bank[3*i +: 3] = 3'(bank);
    req_addr[WIDTH*i +: WIDTH] = 16'(addr);
    req_wdata[8*i +: 8] = 8'(wd);
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 2, 3, 8'hEE);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (mem_we !== 6'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=000000", mem_we); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=00000000", rsp_rdata); end
    @(negedge clk); idle_all(); reset = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 2, 3, 8'hA5);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready got=%b want=0001", req_ready); end
    total++; if (mem_we !== 6'b000100) begin bad++; $display("FAIL wr_mem_we got=%b want=000100", mem_we); end
    total++; if (mem_a[32 +: 16] !== 16'd3) begin bad++; $display("FAIL wr_mem_a got=%h want=0003", mem_a[32 +: 16]); end
    total++; if (mem_wd[32 +: 16] !== 16'h00A5) begin bad++; $display("FAIL wr_mem_wd got=%h want=00a5", mem_wd[32 +: 16]); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL wr_no_rsp got=%b want=0000", rsp_valid); end
    @(negedge clk); idle_all(); set_req(1, 1'b0, 2, 3, 0);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rd_ready got=%b want=0010", req_ready); end
    total++; if (mem_we !== 6'b0) begin bad++; $display("FAIL rd_mem_we got=%b want=000000", mem_we); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL rd_rsp_valid got=%b want=0010", rsp_valid); end
    total++; if (rsp_rdata[15:8] !== 8'hA5) begin bad++; $display("FAIL rd_rsp_rdata got=%h want=a5", rsp_rdata[15:8]); end
    @(negedge clk); idle_all();
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rd_rsp_drop got=%b want=0000", rsp_valid); end
    total++; if (rsp_rdata[15:8] !== 8'hA5) begin bad++; $display("FAIL rd_rsp_hold got=%h want=a5", rsp_rdata[15:8]); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, i, 0);
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL cont_ready[%0d] got=%b want=%b", c, req_ready, 4'(1 << (c % 4))); end
      @(posedge clk); #1;
      total++; if (rsp_valid !== 4'(1 << (c % 4))) begin bad++; $display("FAIL cont_rsp_valid[%0d] got=%b want=%b", c, rsp_valid, 4'(1 << (c % 4))); end
      total++; if (rsp_rdata[8*(c%4) +: 8] !== exp_byte(0, c % 4)) begin bad++; $display("FAIL cont_rdata[%0d] got=%h want=%h", c, rsp_rdata[8*(c%4) +: 8], exp_byte(0, c % 4)); end
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic test_parallel();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, 5, 0);
    #1;
    total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL par_ready got=%b want=1111", req_ready); end
    total++; if (mem_we !== 6'b0) begin bad++; $display("FAIL par_mem_we got=%b want=000000", mem_we); end
    total++; if (mem_a !== {16'd0, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5}) begin bad++; $display("FAIL par_mem_a got=%h want=000000000005000500050005", mem_a); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b1111) begin bad++; $display("FAIL par_rsp_valid got=%b want=1111", rsp_valid); end
    for (int i = 0; i < NREQ; i++) begin
      total++; if (rsp_rdata[8*i +: 8] !== exp_byte(i, 5)) begin bad++; $display("FAIL par_rdata[%0d] got=%h want=%h", i, rsp_rdata[8*i +: 8], exp_byte(i, 5)); end
    end
    @(negedge clk); idle_all();
  endtask

  task automatic test_ptr_indep();
    int ord [3] = '{0, 2, 0};
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    set_req(0, 1'b0, 1, 1, 0); set_req(2, 1'b0, 1, 2, 0); set_req(3, 1'b0, 4, 4, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== (4'(1 << ord[c]) | 4'b1000)) begin bad++; $display("FAIL ptr_ready[%0d] got=%b want=%b", c, req_ready, 4'(1 << ord[c]) | 4'b1000); end
      @(posedge clk); #1;
      total++; if (rsp_rdata[8*ord[c] +: 8] !== exp_byte(1, (ord[c] == 0) ? 1 : 2)) begin bad++; $display("FAIL ptr_rdata[%0d] got=%h want=%h", c, rsp_rdata[8*ord[c] +: 8], exp_byte(1, (ord[c] == 0) ? 1 : 2)); end
      total++; if (rsp_rdata[31:24] !== exp_byte(4, 4)) begin bad++; $display("FAIL ptr_b4_rdata[%0d] got=%h want=%h", c, rsp_rdata[31:24], exp_byte(4, 4)); end
      @(negedge clk);
    end
    idle_all(); set_req(0, 1'b0, 4, 6, 0); set_req(3, 1'b0, 4, 4, 0);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ptr4_settled got=%b want=0001", req_ready); end
    @(posedge clk); @(negedge clk); idle_all();
  endtask

  task automatic test_oor();
    set_req(2, 1'b0, 7, 9, 0);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL oor_ready got=%b want=0100", req_ready); end
    total++; if (mem_we !== 6'b0 || mem_a !== '0) begin bad++; $display("FAIL oor_no_access got we=%b a=%h want we=000000 a=0", mem_we, mem_a); end
`ifdef MEMARB_ERR_EN
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL oor_err_pre got=%b want=0", err_flag); end
`endif
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL oor_rsp_valid got=%b want=0100", rsp_valid); end
    total++; if (rsp_rdata[23:16] !== 8'h00) begin bad++; $display("FAIL oor_rdata got=%h want=00", rsp_rdata[23:16]); end
`ifdef MEMARB_ERR_EN
    total++; if (err_flag !== 1'b1 || err_req !== 2'd2) begin bad++; $display("FAIL oor_err got flag=%b req=%0d want flag=1 req=2", err_flag, err_req); end
`endif
    @(negedge clk); idle_all(); set_req(1, 1'b1, 6, 0, 8'h55);
    #1;
    total++; if (req_ready !== 4'b0010 || mem_we !== 6'b0) begin bad++; $display("FAIL oor_wr got ready=%b we=%b want ready=0010 we=000000", req_ready, mem_we); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL oor_wr_no_rsp got=%b want=0000", rsp_valid); end
`ifdef MEMARB_ERR_EN
    total++; if (err_flag !== 1'b1 || err_req !== 2'd2) begin bad++; $display("FAIL oor_err_sticky got flag=%b req=%0d want flag=1 req=2", err_flag, err_req); end
`endif
    @(negedge clk); idle_all();
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b1, 5, 7, 8'h3C);
    #1;
    total++; if (mem_we !== 6'b100000 || mem_wd[80 +: 16] !== 16'h003C) begin bad++; $display("FAIL b2b_wr got we=%b wd=%h want we=100000 wd=003c", mem_we, mem_wd[80 +: 16]); end
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, 5, 7, 0);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL b2b_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0001 || rsp_rdata[7:0] !== 8'h3C) begin bad++; $display("FAIL b2b_rd got valid=%b data=%h want valid=0001 data=3c", rsp_valid, rsp_rdata[7:0]); end
    @(negedge clk); idle_all();
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b0, 3, 2, 0);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rst_mid_accept got=%b want=0010", req_ready); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL rst_mid_rsp got=%b want=0010", rsp_valid); end
    @(negedge clk); reset = 1'b1; idle_all(); set_req(0, 1'b1, 3, 2, 8'hFF);
    #1;
    total++; if (req_ready !== 4'b0000 || mem_we !== 6'b0) begin bad++; $display("FAIL rst_mid_gate got ready=%b we=%b want ready=0000 we=000000", req_ready, mem_we); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_drop got valid=%b data=%h want valid=0000 data=0", rsp_valid, rsp_rdata); end
`ifdef MEMARB_ERR_EN
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL rst_mid_err_clr got=%b want=0", err_flag); end
`endif
    @(negedge clk); reset = 1'b0; idle_all(); set_req(1, 1'b0, 3, 2, 0); set_req(3, 1'b0, 3, 3, 0);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rst_mid_ptr got=%b want=0010", req_ready); end
    @(posedge clk); #1;
    total++; if (rsp_rdata[15:8] !== exp_byte(3, 2)) begin bad++; $display("FAIL rst_mid_nowrite got=%h want=%h", rsp_rdata[15:8], exp_byte(3, 2)); end
    @(negedge clk); idle_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_parallel();
    test_ptr_indep();
    test_oor();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bank_arbiter.md
Name: mem_bank_arbiter

Overview:
- Shares the six byte-wide banks of unifiedmem between NREQ independent requesters (pipeline lanes / load-store ports).
- Each requester issues single-byte read or write transactions tagged with a bank index and an in-bank address.
- Per-bank round-robin arbitration; one access per bank per cycle; registered read responses.
- Sits between the requesters and unifiedmem, driving its packed we/a/wd buses and sampling rd.

Parameters:
- WIDTH, 16, address width per bank; matches unifiedmem WIDTH.
- NREQ, 4, number of requesters (2..8).
- NBANK, 6, number of banks; fixed to the memory's bank count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request i pending.
- req_ready  output  NREQ  request i accepted this cycle (valid & ready = transfer).
- req_we  input  NREQ  1 = write, 0 = read.
- req_bank  input  NREQ*3  target bank index of requester i (bits [3i+2:3i]).
- req_addr  input  NREQ*WIDTH  in-bank address.
- req_wdata  input  NREQ*8  write byte.
- rsp_valid  output  NREQ  read data valid for requester i.
- rsp_rdata  output  NREQ*8  read byte for requester i.
- mem_we  output  6  to unifiedmem we.
- mem_a  output  WIDTH*6  to unifiedmem a; bank b uses slice [WIDTH*(b+1)-1:WIDTH*b].
- mem_wd  output  WIDTH*6  to unifiedmem wd; byte zero-extended to WIDTH.
- mem_rd  input  8*6  from unifiedmem rd; combinational read data.

Behaviour:
- State: per-bank priority pointer ptr[b] (log2 NREQ bits); response registers rsp_valid and rsp_rdata.
- Arbitration (combinational, per bank b):
  - Candidates are requesters with req_valid=1 and req_bank=b.
  - Winner is the first candidate at or after ptr[b], scanning upward modulo NREQ.
  - req_ready[winner]=1. Losers see ready=0 and must hold valid and all request fields stable.
- Pointer update: on a grant in bank b, ptr[b] <= winner+1 mod NREQ at posedge. A bank with no grant keeps its pointer.
- Fairness: a continuously-valid requester waits at most NREQ-1 cycles.
- Memory drive for granted bank b:
  - mem_a slice = req_addr[winner].
  - mem_we[b] = req_we[winner].
  - mem_wd slice = {0, req_wdata[winner]}.
- Ungranted bank: we=0, a=0, wd=0.
- Reads:
  - rsp_valid[i] <= 1 and rsp_rdata[i] <= mem_rd byte of the granted bank, registered at the posedge ending the grant cycle.
  - Latency is exactly 1 cycle after the accept.
  - Otherwise rsp_valid[i] <= 0; rsp_rdata holds its last value.
- Writes: committed by unifiedmem at the same posedge; no response.
- Ordering:
  - A read of the same bank/address in the cycle after a write returns the new byte.
  - Each requester has at most one grant per cycle because it has a single request.
- Out-of-range bank (req_bank >= NBANK):
  - Accepted immediately (ready=1), with no memory access.
  - For a read, rsp_valid pulses with rsp_rdata=8'h00.
- Reset (synchronous, checked at posedge):
  - ptr[*]=0, rsp_valid=0, rsp_rdata=0.
  - While reset is high: req_ready=0 and mem_we=0, combinationally gated.
  - Reset mid-transaction drops any pending response; no write occurs in a reset cycle.

Optional Feature:
- Macro MEMARB_ERR_EN.
- When defined, adds two outputs:
  - err_flag (1 bit): sticky; set by any accepted out-of-range request; cleared only by reset.
  - err_req (log2 NREQ bits): index of the first offending requester, captured only while err_flag=0.
  - If several requesters offend in the same cycle, err_req takes the lowest index.
- When undefined, these ports and their logic are absent; out-of-range handling is otherwise identical.

Test Plan:
- Single read: after reset, write 8'hA5 to bank 2 addr 3 (requester 0), then read it from requester 1 → rsp_valid[1] one cycle after accept, rsp_rdata=8'hA5; mem_we=6'b000100 only in the write cycle.
- Contention: all 4 requesters hold valid reads to bank 0 for 8 cycles → grant order 0,1,2,3,0,1,2,3; exactly one ready per cycle.
- Parallel banks: requesters 0..3 read banks 0..3 in the same cycle → all four ready in that cycle; four rsp_valid next cycle with the corresponding bytes.
- Pointer independence: bank 1 contention (req 0,2) while bank 4 serves req 3 alone → bank 1 order 0,2,0; bank 4 grants req 3 every cycle; ptr[4] settles at 0.
- Out-of-range: requester 2 reads bank 7 → ready same cycle, mem_we=0, rsp_rdata=8'h00; with MEMARB_ERR_EN, err_flag=1 and err_req=2 sticky until reset.
- Reset mid-stream: assert reset in the cycle after an accepted read → rsp_valid=0 after the posedge, ptr=0, and no mem_we during reset.
